ir_tx_scheduler: RTL

- Shares one IR LED transmitter among NUM_REQ command sources, e.g. per-key Samsung command generators that emit a 32-bit word for one cycle, with 0 meaning idle.
- Latches each source's request in a one-deep slot and grants slots round-robin.
- Serialises the granted word as a Samsung/NEC-style pulse-distance frame with 38 kHz carrier.
- Sits between the command generators and the board GPIO driving the IR LED.

---
 rtl/ir_pkg.sv | 19 +
 rtl/ir_rr_arbiter.sv | 25 ++
 rtl/ir_tx_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared state encoding and frame timing constants for the IR transmit scheduler.
package ir_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } ir_state_t;
  localparam int LEAD_MARK_UNITS  = 8;
  localparam int LEAD_SPACE_UNITS = 8;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int BIT_MARK_UNITS   = 1;
  localparam int STOP_UNITS       = 1;
  localparam int FRAME_BITS       = 32;
endpackage

// File: rtl/ir_rr_arbiter.sv
// ir_rr_arbiter: combinational round-robin pick of the first set request after the last grant.
module ir_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W-1:0]       last,
  output logic               valid,
  output logic [W-1:0]       idx
);
  logic [W-1:0] j;
  // Scan from farthest to nearest so the nearest set request after last wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    j     = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = W'((int'(last) + k) % NUM_REQ);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end
endmodule

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: round-robin sharing of one IR LED among command sources, sending
// each granted word as a pulse-distance frame on a 38 kHz carrier.
module ir_tx_scheduler
  import ir_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int UNIT_CYCLES = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int GAP_UNITS   = 80,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      cmd_valid,
  input  logic [NUM_REQ*32-1:0]   cmd_data,
  output logic                    ir_out,
  output logic                    ir_env,
  output logic                    busy,
  output logic [W-1:0]            grant_id,
  output logic                    frame_done,
  output logic [NUM_REQ-1:0]      drop
);
  localparam int UW = $clog2(UNIT_CYCLES + 1);
  localparam int MAXU = GAP_UNITS > LEAD_MARK_UNITS ? GAP_UNITS : LEAD_MARK_UNITS;
  localparam int RW = $clog2(MAXU + 1);
  localparam int CW = $clog2(CARRIER_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS);

  ir_state_t            state;
  logic [31:0]          slot [NUM_REQ];
  logic [NUM_REQ-1:0]   full;
  logic [NUM_REQ-1:0]   clr;
  logic [W-1:0]         last;
  logic [W-1:0]         gi;
  logic                 gv;
  logic                 take;
  logic [31:0]          sh;
  logic [BW-1:0]        bidx;
  logic [UW-1:0]        ucnt;
  logic [RW-1:0]        rem;
  logic [CW-1:0]        ccnt;
  logic                 unit_end;
  logic                 state_end;

  ir_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (full),
    .last  (last),
    .valid (gv),
    .idx   (gi)
  );

  assign take       = state == IDLE && gv;
  assign clr        = take ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gi : '0;
  assign unit_end   = ucnt == UW'(UNIT_CYCLES - 1);
  assign state_end  = unit_end && rem == '0;
  assign frame_done = state == GAP && state_end;
  assign ir_out     = ir_env && ccnt < CW'(CARRIER_DIV / 2);

  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (cmd_valid[i] && !full[i]) slot[i] <= cmd_data[i*32 +: 32];

  // A strobe on the grant edge still sees the slot full, so it is dropped.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      full <= '0;
      drop <= '0;
    end else begin
      full <= (full & ~clr) | (cmd_valid & ~full);
      drop <= cmd_valid & full;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      last     <= W'(NUM_REQ - 1);
      grant_id <= '0;
      busy     <= 1'b0;
      ir_env   <= 1'b0;
      sh       <= '0;
      bidx     <= '0;
      ucnt     <= '0;
      rem      <= '0;
      ccnt     <= '0;
    end else begin
      ucnt <= unit_end ? '0 : ucnt + 1'b1;
      rem  <= unit_end ? rem - 1'b1 : rem;
      ccnt <= ccnt == CW'(CARRIER_DIV - 1) ? '0 : ccnt + 1'b1;
      case (state)
        IDLE: begin
          ucnt <= '0;
          if (take) begin
            state    <= LEAD_MARK;
            sh       <= slot[gi];
            grant_id <= gi;
            last     <= gi;
            busy     <= 1'b1;
            ir_env   <= 1'b1;
            rem      <= RW'(LEAD_MARK_UNITS - 1);
            ccnt     <= '0;
          end
        end
        LEAD_MARK: if (state_end) begin
          state  <= LEAD_SPACE;
          ir_env <= 1'b0;
          rem    <= RW'(LEAD_SPACE_UNITS - 1);
        end
        LEAD_SPACE: if (state_end) begin
          state  <= BIT_MARK;
          bidx   <= BW'(FRAME_BITS - 1);
          ir_env <= 1'b1;
          rem    <= RW'(BIT_MARK_UNITS - 1);
          ccnt   <= '0;
        end
        BIT_MARK: if (state_end) begin
          state  <= BIT_SPACE;
          ir_env <= 1'b0;
          rem    <= sh[31] ? RW'(ONE_SPACE_UNITS - 1) : RW'(ZERO_SPACE_UNITS - 1);
        end
        BIT_SPACE: if (state_end) begin
          state  <= bidx != '0 ? BIT_MARK : STOP_MARK;
          bidx   <= bidx != '0 ? bidx - 1'b1 : bidx;
          sh     <= {sh[30:0], 1'b0};
          ir_env <= 1'b1;
          rem    <= bidx != '0 ? RW'(BIT_MARK_UNITS - 1) : RW'(STOP_UNITS - 1);
          ccnt   <= '0;
        end
        STOP_MARK: if (state_end) begin
          state  <= GAP;
          ir_env <= 1'b0;
          rem    <= RW'(GAP_UNITS - 1);
        end
        GAP: if (state_end) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
